// File: rtl/score_display.sv
// score_display: consumer end of the packed-BCD score bus.
// Takes a snapshot of the live score at each end-of-frame tick and keeps the
// session high score. It also drives a 4-digit multiplexed common-cathode
// 7-segment display, with optional blanking of leading zero digits.
module score_display #(
  parameter int SCAN_DIV      = 1024,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic        show_high,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic [15:0] high_score,
  output logic        new_high
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   snap;
  logic [PW-1:0] prescale;
  logic [1:0]    digit_idx;

  logic          score_valid;
  logic          beats_high;
  logic [15:0]   disp_val;
  logic [3:0]    cur_nibble;
  logic          cur_blank;
  logic          lead_zero_3;
  logic          lead_zero_2;
  logic          lead_zero_1;
  logic [6:0]    next_seg;
  logic [3:0]    next_dig_en;

  // Segment pattern {g,f,e,d,c,b,a} for one BCD nibble; non-BCD shows a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    return pattern;
  endfunction

  // The live score counts as a candidate only if every nibble is a BCD digit.
  // For valid BCD, plain unsigned order matches numeric order.
  always_comb begin
    score_valid = (score[3:0]   <= 4'd9) && (score[7:4]   <= 4'd9) &&
                  (score[11:8]  <= 4'd9) && (score[15:12] <= 4'd9);
    beats_high  = score > high_score;
  end

  // Frame snapshot: capture the live score on each end-of-frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= 16'h0000;
    end else if (game_tick) begin
      snap <= score;
    end
  end

  // High-score tracking: replace on a strictly higher valid score at game over.
  // new_high is a one-cycle flag that follows the replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score <= 16'h0000;
      new_high   <= 1'b0;
    end else if (game_over && score_valid && beats_high) begin
      high_score <= score;
      new_high   <= 1'b1;
    end else begin
      new_high   <= 1'b0;
    end
  end

  // Scan timing: the prescaler wraps every SCAN_DIV cycles and steps the digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= '0;
      digit_idx <= 2'd0;
    end else if (prescale == PRESCALE_LAST) begin
      prescale  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescale  <= prescale + 1'b1;
    end
  end

  // Pick the value being shown and work out the pattern for the current digit.
  // A digit is blanked only when it and every digit above it are zero.
  always_comb begin
    disp_val    = show_high ? high_score : snap;
    lead_zero_3 = (disp_val[15:12] == 4'd0);
    lead_zero_2 = lead_zero_3 && (disp_val[11:8] == 4'd0);
    lead_zero_1 = lead_zero_2 && (disp_val[7:4] == 4'd0);
    cur_nibble  = disp_val[3:0];
    cur_blank   = 1'b0;
    case (digit_idx)
      2'd0: begin
        cur_nibble = disp_val[3:0];
        cur_blank  = 1'b0;
      end
      2'd1: begin
        cur_nibble = disp_val[7:4];
        cur_blank  = lead_zero_1;
      end
      2'd2: begin
        cur_nibble = disp_val[11:8];
        cur_blank  = lead_zero_2;
      end
      default: begin
        cur_nibble = disp_val[15:12];
        cur_blank  = lead_zero_3;
      end
    endcase
    next_seg    = (BLANK_LEADING && cur_blank) ? 7'h00 : decode_bcd(cur_nibble);
    next_dig_en = 4'b0001 << digit_idx;
  end

  // Pin registers: segment pattern and digit enable always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= 7'h00;
      dig_en <= 4'b0000;
    end else begin
      seg    <= next_seg;
      dig_en <= next_dig_en;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display.
// Runs two instances with SCAN_DIV=4 on shared inputs. One has leading-zero
// blanking enabled and the other has it disabled.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] score;
  logic        game_tick;
  logic        game_over;
  logic        show_high;

  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] high_score;
  logic        new_high;

  logic [6:0]  seg_nb;
  logic [3:0]  dig_en_nb;
  logic [15:0] high_score_nb;
  logic        new_high_nb;

  int checks = 0;
  int errors = 0;

  score_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score      (score),
    .game_tick  (game_tick),
    .game_over  (game_over),
    .show_high  (show_high),
    .seg        (seg),
    .dig_en     (dig_en),
    .high_score (high_score),
    .new_high   (new_high)
  );

  score_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .score      (score),
    .game_tick  (game_tick),
    .game_over  (game_over),
    .show_high  (show_high),
    .seg        (seg_nb),
    .dig_en     (dig_en_nb),
    .high_score (high_score_nb),
    .new_high   (new_high_nb)
  );

  // Free-running clock with a 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs from a negedge, then drop the pulses at the next negedge.
  task automatic applyStimulus(input logic tick, input logic over, input logic [15:0] value);
    score     = value;
    game_tick = tick;
    game_over = over;
    @(negedge clk);
    game_tick = 1'b0;
    game_over = 1'b0;
  endtask

  // Wait, with a bound, for the digit 3 -> digit 0 changeover.
  task automatic alignScan(input string tag);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = dig_en;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b1000 && dig_en == 4'b0001) found = 1'b1;
      else prev = dig_en;
    end
    checkOutput({tag, "_align"}, 16'(found), 16'd1);
  endtask

  // Check digit enables and segments over a scan period.
  // The expected patterns are packed as {d3,d2,d1,d0} bytes. show_high is
  // optionally toggled after sample toggleAt, and the B patterns apply from
  // the following sample onward.
  task automatic checkScan(input string tag, input logic [31:0] expA, input logic [31:0] nbA,
                           input logic [31:0] expB, input logic [31:0] nbB,
                           input int toggleAt, input int cycles);
    logic [31:0] cur;
    logic [31:0] curNb;
    int          d;
    alignScan(tag);
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) @(negedge clk);
      d     = (k / 4) % 4;
      cur   = (toggleAt >= 0 && k > toggleAt) ? expB : expA;
      curNb = (toggleAt >= 0 && k > toggleAt) ? nbB : nbA;
      checkOutput({tag, "_dig_en"}, 16'(dig_en), 16'(4'b0001 << d));
      checkOutput({tag, "_seg"}, 16'(seg), 16'(cur[d*8 +: 7]));
      checkOutput({tag, "_seg_noblank"}, 16'(seg_nb), 16'(curNb[d*8 +: 7]));
      if (k == toggleAt) show_high = ~show_high;
    end
  endtask

  // Directed test sequence.
  initial begin
    rst_n     = 1'b0;
    score     = 16'h0000;
    game_tick = 1'b0;
    game_over = 1'b0;
    show_high = 1'b0;
    $display("[TB] starting score_display bench");

    #3;
    checkOutput("rst_seg", 16'(seg), 16'h0000);
    checkOutput("rst_dig_en", 16'(dig_en), 16'h0000);
    checkOutput("rst_high_score", high_score, 16'h0000);
    checkOutput("rst_new_high", 16'(new_high), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_dig_en", 16'(dig_en), 16'h0001);
    checkOutput("first_seg", 16'(seg), 16'h003F);

    // Scan pattern for a full-width score, checked over two periods.
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkScan("s1234", 32'h065B4F66, 32'h065B4F66, 32'h0, 32'h0, -1, 32);

    // Leading-zero blanking.
    applyStimulus(1'b1, 1'b0, 16'h0042);
    checkScan("s0042", 32'h0000665B, 32'h3F3F665B, 32'h0, 32'h0, -1, 16);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkScan("s0000", 32'h0000003F, 32'h3F3F3F3F, 32'h0, 32'h0, -1, 16);

    // High score: a new high, then equal, smaller and invalid scores.
    applyStimulus(1'b0, 1'b1, 16'h0150);
    checkOutput("hi_0150", high_score, 16'h0150);
    checkOutput("hi_0150_pulse", 16'(new_high), 16'h0001);
    @(negedge clk);
    checkOutput("hi_0150_pulse_end", 16'(new_high), 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0150);
    checkOutput("hi_equal", high_score, 16'h0150);
    checkOutput("hi_equal_pulse", 16'(new_high), 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0099);
    checkOutput("hi_smaller", high_score, 16'h0150);
    checkOutput("hi_smaller_pulse", 16'(new_high), 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0A00);
    checkOutput("hi_invalid", high_score, 16'h0150);
    checkOutput("hi_invalid_pulse", 16'(new_high), 16'h0000);

    // Tick and game_over together with an invalid score: dash shown, high kept.
    applyStimulus(1'b1, 1'b1, 16'h00A1);
    checkOutput("dash_high", high_score, 16'h0150);
    checkOutput("dash_pulse", 16'(new_high), 16'h0000);
    checkScan("s00A1", 32'h00004006, 32'h3F3F4006, 32'h0, 32'h0, -1, 16);

    // show_high toggled mid-scan.
    applyStimulus(1'b1, 1'b0, 16'h0007);
    checkScan("toggle", 32'h00000007, 32'h3F3F3F07, 32'h00066D3F, 32'h3F066D3F, 6, 16);
    show_high = 1'b0;

    // Tick and game_over together with a valid, higher score.
    applyStimulus(1'b1, 1'b1, 16'h0300);
    checkOutput("both_high", high_score, 16'h0300);
    checkOutput("both_pulse", 16'(new_high), 16'h0001);
    checkScan("s0300", 32'h004F3F3F, 32'h3F4F3F3F, 32'h0, 32'h0, -1, 16);

    // Asynchronous reset mid-operation, with a new_high pulse pending.
    score     = 16'h0400;
    game_over = 1'b1;
    @(posedge clk);
    #1;
    game_over = 1'b0;
    checkOutput("pre_rst_pulse", 16'(new_high), 16'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_seg", 16'(seg), 16'h0000);
    checkOutput("mid_rst_dig_en", 16'(dig_en), 16'h0000);
    checkOutput("mid_rst_high_score", high_score, 16'h0000);
    checkOutput("mid_rst_new_high", 16'(new_high), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_dig_en", 16'(dig_en), 16'h0001);
    checkOutput("post_rst_seg", 16'(seg), 16'h003F);
    checkOutput("post_rst_high_score", high_score, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
